// File: rtl/prog_clk_div_pkg.sv
// Shared constants and helpers for the programmable multi-channel clock divider.
//   DEF_NUM_CH / DEF_WIDTH / DEF_RST_DIV : default parameter values
//   ch_idx_w(n)                          : channel-index width, never below 1
package prog_clk_div_pkg;

  localparam int unsigned DEF_NUM_CH  = 4;
  localparam int unsigned DEF_WIDTH   = 17;
  localparam int unsigned DEF_RST_DIV = 100000;

  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prog_clk_div_ch.sv
// One divider channel: up-counter against an active divisor, with a shadow
// divisor that is only promoted at a half-period boundary (or while idle/synced).
//   clk_in, rst_n : clock, async active-low reset
//   en_i          : run enable
//   sync_i        : phase-align request (tied low when the feature is absent)
//   wr_i, wr_div_i: shadow divisor write strobe and value
//   pend_o        : shadow divisor waiting to be applied
//   clk_o, tick_o : divided clock and half-period terminal pulse (registered)
module prog_clk_div_ch #(
  parameter int unsigned WIDTH   = 17,
  parameter int unsigned RST_DIV = 100000
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wr_div_i,
  output logic             pend_o,
  output logic             clk_o,
  output logic             tick_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] shd_q, shd_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             term_c;

  // cnt > div cannot happen in normal operation but is still treated as terminal
  assign term_c = (cnt_q >= div_q);

  // State register
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      div_q  <= WIDTH'(RST_DIV);
      shd_q  <= WIDTH'(RST_DIV);
      pend_q <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  // Next-state: idle/sync, terminal count, or plain increment; write applied last
  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    clk_d  = clk_q;
    tick_d = 1'b0;

    if (!en_i || sync_i) begin
      cnt_d = '0;
      clk_d = 1'b0;
      if (pend_q) begin
        div_d  = shd_q;
        pend_d = 1'b0;
      end
    end else if (term_c) begin
      cnt_d  = '0;
      clk_d  = ~clk_q;
      tick_d = 1'b1;
      if (pend_q) begin
        div_d  = shd_q;
        pend_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + WIDTH'(1);
    end

    // A write landing on an apply cycle becomes the next pending value
    if (wr_i) begin
      shd_d  = wr_div_i;
      pend_d = 1'b1;
    end
  end

  assign pend_o = pend_q;
  assign clk_o  = clk_q;
  assign tick_o = tick_q;

endmodule

// File: rtl/prog_clk_div.sv
// Programmable multi-channel 50%-duty clock divider with glitch-free divisor update.
//   clk_in, rst_n : clock, async active-low reset
//   en            : per-channel run enable
//   wr_en/wr_ch/wr_div : divisor write (out-of-range channel ignored)
//   sync          : only with PROG_CLK_DIV_SYNC_EN; phase-aligns all enabled channels
//   pend, clk_out, tick : per-channel status and registered outputs
// Optional feature macro: PROG_CLK_DIV_SYNC_EN
module prog_clk_div
  import prog_clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH  = DEF_NUM_CH,
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned RST_DIV = DEF_RST_DIV
) (
  input  logic                          clk_in,
  input  logic                          rst_n,
  input  logic [NUM_CH-1:0]             en,
  input  logic                          wr_en,
  input  logic [ch_idx_w(NUM_CH)-1:0]   wr_ch,
  input  logic [WIDTH-1:0]              wr_div,
`ifdef PROG_CLK_DIV_SYNC_EN
  input  logic                          sync,
`endif
  output logic [NUM_CH-1:0]             pend,
  output logic [NUM_CH-1:0]             clk_out,
  output logic [NUM_CH-1:0]             tick
);

  localparam int unsigned CH_W = ch_idx_w(NUM_CH);

  logic sync_c;

`ifdef PROG_CLK_DIV_SYNC_EN
  assign sync_c = sync;
`else
  assign sync_c = 1'b0;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic wr_hit_c;

    // Channel indices >= NUM_CH never match any instance
    assign wr_hit_c = wr_en && (wr_ch == CH_W'(g));

    prog_clk_div_ch #(
      .WIDTH   (WIDTH),
      .RST_DIV (RST_DIV)
    ) u_ch (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .en_i     (en[g]),
      .sync_i   (sync_c),
      .wr_i     (wr_hit_c),
      .wr_div_i (wr_div),
      .pend_o   (pend[g]),
      .clk_o    (clk_out[g]),
      .tick_o   (tick[g])
    );
  end

endmodule

// File: tb/tb_prog_clk_div.sv
// Bench for prog_clk_div: directed scenarios plus random traffic against a
// countdown-based reference model (cycles remaining in the current half-period).
module tb_prog_clk_div;

  localparam int unsigned NCH = 3;
  localparam int unsigned W   = 8;
  localparam int unsigned RD  = 3;

  logic           clk_in = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] en;
  logic           wr_en;
  logic [1:0]     wr_ch;
  logic [W-1:0]   wr_div;
  logic           sync;
  logic [NCH-1:0] pend, clk_out, tick;

  always #5 clk_in = ~clk_in;

  prog_clk_div #(.NUM_CH(NCH), .WIDTH(W), .RST_DIV(RD)) dut (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .en      (en),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_div  (wr_div),
`ifdef PROG_CLK_DIV_SYNC_EN
    .sync    (sync),
`endif
    .pend    (pend),
    .clk_out (clk_out),
    .tick    (tick)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: per channel, cycles left until the next half-period boundary
  int m_div  [NCH];
  int m_shd  [NCH];
  int m_left [NCH];
  bit m_pend [NCH];
  bit m_clk  [NCH];
  bit m_tick [NCH];

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_div[i]  = RD;
      m_shd[i]  = RD;
      m_pend[i] = 1'b0;
      m_clk[i]  = 1'b0;
      m_tick[i] = 1'b0;
      m_left[i] = RD + 1;
    end
  endfunction

  function automatic void model_edge(input logic [NCH-1:0] e, input bit s,
                                     input bit w, input int ch, input int d);
    for (int i = 0; i < NCH; i++) begin
      if (!e[i] || s) begin
        m_clk[i]  = 1'b0;
        m_tick[i] = 1'b0;
        if (m_pend[i]) begin m_div[i] = m_shd[i]; m_pend[i] = 1'b0; end
        m_left[i] = m_div[i] + 1;
      end else begin
        m_left[i] = m_left[i] - 1;
        if (m_left[i] == 0) begin
          m_tick[i] = 1'b1;
          m_clk[i]  = !m_clk[i];
          if (m_pend[i]) begin m_div[i] = m_shd[i]; m_pend[i] = 1'b0; end
          m_left[i] = m_div[i] + 1;
        end else begin
          m_tick[i] = 1'b0;
        end
      end
    end
    if (w && ch < NCH) begin
      m_shd[ch]  = d;
      m_pend[ch] = 1'b1;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [NCH-1:0] ep, ec, et;
    for (int i = 0; i < NCH; i++) begin
      ep[i] = m_pend[i];
      ec[i] = m_clk[i];
      et[i] = m_tick[i];
    end
    chk({tag, "_pend"}, 32'(pend), 32'(ep));
    chk({tag, "_clk"},  32'(clk_out), 32'(ec));
    chk({tag, "_tick"}, 32'(tick), 32'(et));
  endtask

  // One clock: sample inputs at the edge, advance model, compare 1 time unit later
  task automatic cyc(input string tag = "cyc");
    logic [NCH-1:0] e;
    bit s, w;
    int ch, d;
    e  = en;
    s  = sync;
    w  = wr_en;
    ch = int'(wr_ch);
    d  = int'(wr_div);
    @(posedge clk_in);
    if (rst_n) model_edge(e, s, w, ch, d);
    #1;
    check_all(tag);
    wr_en = 1'b0;
    sync  = 1'b0;
  endtask

  task automatic wr(input int ch, input int d);
    wr_en  = 1'b1;
    wr_ch  = 2'(ch);
    wr_div = W'(d);
    cyc("wr");
  endtask

  initial begin
    rst_n  = 1'b0;
    en     = '0;
    wr_en  = 1'b0;
    wr_ch  = '0;
    wr_div = '0;
    sync   = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    chk("reset_clk_zero", 32'(clk_out), 32'd0);
    rst_n = 1'b1;

    // Reset divisor 3: first tick on the 4th edge after enable
    en[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc("first");
      if (k == 3) chk("first_tick_early", 32'(tick[0]), 32'd0);
      if (k == 4) chk("first_tick", 32'(tick[0]), 32'd1);
    end
    for (int k = 0; k < 12; k++) cyc("run3");

    // Mid-period write of 1: pending until the boundary
    for (int k = 0; k < 10 && m_left[0] != 3; k++) cyc("seek_mid");
    wr(0, 1);
    chk("mid_wr_pend", 32'(pend[0]), 32'd1);
    cyc("mid_wr_hold");
    chk("mid_wr_pend_hold", 32'(pend[0]), 32'd1);
    for (int k = 0; k < 10; k++) cyc("run1");

    // Write of 5 on the terminal-count cycle: old divisor completes this half
    for (int k = 0; k < 20 && m_left[0] != 1; k++) cyc("seek_tc");
    wr(0, 5);
    chk("tc_wr_tick", 32'(tick[0]), 32'd1);
    chk("tc_wr_pend", 32'(pend[0]), 32'd1);
    for (int k = 0; k < 16; k++) cyc("run5");

    // Disable with a pending 7, then re-enable: first tick after 8 edges
    wr(0, 7);
    en[0] = 1'b0;
    cyc("dis");
    chk("dis_pend_clear", 32'(pend[0]), 32'd0);
    chk("dis_clk_low", 32'(clk_out[0]), 32'd0);
    en[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc("reen");
      if (k == 7) chk("reen_tick_early", 32'(tick[0]), 32'd0);
      if (k == 8) chk("reen_tick", 32'(tick[0]), 32'd1);
    end

    // Out-of-range channel write is ignored
    wr(3, 9);
    chk("oor_pend", 32'(pend), 32'd0);
    for (int k = 0; k < 10; k++) cyc("oor_run");

`ifdef PROG_CLK_DIV_SYNC_EN
    // Sync aligns ch0 (div 2) and ch1 (div 4)
    en = '0;
    wr(0, 2);
    wr(1, 4);
    cyc("sync_apply");
    en = 3'b011;
    for (int k = 0; k < 7; k++) cyc("sync_pre");
    sync = 1'b1;
    cyc("sync");
    chk("sync_clk_low", 32'(clk_out[1:0]), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      cyc("sync_post");
      if (k == 3) chk("sync_tick0", 32'(tick[0]), 32'd1);
      if (k == 5) chk("sync_tick1", 32'(tick[1]), 32'd1);
    end
`endif

    // Random traffic
    for (int k = 0; k < 500; k++) begin
      if (k % 25 == 0) en = NCH'($urandom_range(0, (1 << NCH) - 1));
      if ($urandom_range(0, 5) == 0) begin
        wr_en  = 1'b1;
        wr_ch  = 2'($urandom_range(0, 3));
        wr_div = W'($urandom_range(0, 9));
      end
`ifdef PROG_CLK_DIV_SYNC_EN
      if ($urandom_range(0, 40) == 0) sync = 1'b1;
`endif
      cyc("rand");
    end

    // Reset mid-period discards a pending write
    en = '1;
    wr(1, 6);
    chk("pre_rst_pend", 32'(pend[1]), 32'd1);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    chk("async_rst_pend", 32'(pend), 32'd0);
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) cyc("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
